// File: rtl/mips_tb_pkg.sv
// rtl/mips_tb_pkg.sv - shared types, default markers and saturating add for the result checker
package mips_tb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam logic [29:0] DEF_TEST_PORT = 30'h3FF;
    localparam logic [31:0] DEF_BEGIN_SYM = 32'h168;
    localparam logic [31:0] DEF_END_SYM   = 32'hD5D;

    // Operands are zero-extended by the caller; result clamps at max_v.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/mips_answer_mem.sv
// rtl/mips_answer_mem.sv - answer table, one write port and one combinational read port
module mips_answer_mem #(
    parameter int DEPTH  = 161,
    parameter int IDX_W  = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Out-of-range indices would alias after truncation, so they are dropped here.
    always_ff @(posedge clk) begin
        if (we && (waddr < DEPTH_IDX)) begin
            mem_q[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = (raddr < DEPTH_IDX) ? mem_q[raddr[AW-1:0]] : '0;

endmodule

// File: rtl/mips_result_checker.sv
// rtl/mips_result_checker.sv - snoops result-port writes and scores them against a loadable answer table
module mips_result_checker
    import mips_tb_pkg::*;
#(
    parameter int                ADDR_W    = 30,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] TEST_PORT = ADDR_W'(DEF_TEST_PORT),
    parameter logic [DATA_W-1:0] BEGIN_SYM = DATA_W'(DEF_BEGIN_SYM),
    parameter logic [DATA_W-1:0] END_SYM   = DATA_W'(DEF_END_SYM),
    parameter int                CHECK_NUM = 161,
    parameter int                IDX_W     = 12,
    parameter int                ERR_W     = 8,
    parameter int                DUR_W     = 16,
    parameter logic [DUR_W-1:0]  TIMEOUT   = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    output logic [ERR_W-1:0]  error_num,
    output logic [DUR_W-1:0]  duration,
    output logic              finish,
    output logic              timeout,
    output logic              early_end,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic              first_err_vld
);

    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(CHECK_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHECK_NUM - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [DUR_W-1:0] DUR_LAST = TIMEOUT - 1'b1;

    state_e            state_q, state_d;
    logic              armed_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              timeout_q, timeout_d;
    logic              early_q, early_d;
    logic [IDX_W-1:0]  ferr_idx_q, ferr_idx_d;
    logic              ferr_vld_q, ferr_vld_d;

    logic              port_hit;
    logic              accept;
    logic              mismatch;
    logic [31:0]       err_sum;
    logic [DATA_W-1:0] rd_data;

    mips_answer_mem #(
        .DEPTH  (CHECK_NUM),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_answer_mem (
        .clk   (clk),
        .we    (ld_en && (state_q != CHECK)),
        .waddr (ld_idx),
        .wdata (ld_data),
        .raddr (idx_q),
        .rdata (rd_data)
    );

    // A write held high across a stall is only seen on its first cycle.
    assign port_hit = wen && (addr == TEST_PORT);
    assign accept   = port_hit && armed_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_d      = err_q;
        dur_d      = dur_q;
        timeout_d  = timeout_q;
        early_d    = early_q;
        ferr_idx_d = ferr_idx_q;
        ferr_vld_d = ferr_vld_q;
        mismatch   = 1'b0;
        err_sum    = 32'(err_q);

        unique case (state_q)
            IDLE: begin
                if (port_hit && (data == BEGIN_SYM)) begin
                    state_d    = CHECK;
                    err_d      = '0;
                    idx_d      = '0;
                    dur_d      = '0;
                    ferr_vld_d = 1'b0;
                end
            end
            CHECK: begin
                dur_d = dur_q + 1'b1;
                if (idx_q == N_IDX) begin
                    state_d = REPORT;
                end else if (accept) begin
                    mismatch = (data != rd_data);
                    idx_d    = idx_q + 1'b1;
                    if (mismatch) begin
                        err_sum = sat_add(err_sum, 32'd1, 32'(ERR_MAX));
                        if (!ferr_vld_q) begin
                            ferr_idx_d = idx_q;
                            ferr_vld_d = 1'b1;
                        end
                    end
                    // Entries that will never arrive are charged as errors.
                    if ((data == END_SYM) && (idx_q < LAST_IDX)) begin
                        err_sum = sat_add(err_sum, 32'(LAST_IDX - idx_q), 32'(ERR_MAX));
                        early_d = 1'b1;
                        state_d = REPORT;
                    end
                    err_d = err_sum[ERR_W-1:0];
                end
                if ((dur_q == DUR_LAST) && (state_d == CHECK)) begin
                    state_d   = REPORT;
                    timeout_d = (idx_d != N_IDX);
                end
            end
            REPORT: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            idx_q      <= '0;
            err_q      <= '1;
            dur_q      <= '0;
            timeout_q  <= 1'b0;
            early_q    <= 1'b0;
            ferr_idx_q <= '0;
            ferr_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= !wen;
            idx_q      <= idx_d;
            err_q      <= err_d;
            dur_q      <= dur_d;
            timeout_q  <= timeout_d;
            early_q    <= early_d;
            ferr_idx_q <= ferr_idx_d;
            ferr_vld_q <= ferr_vld_d;
        end
    end

    assign error_num     = err_q;
    assign duration      = dur_q;
    assign finish        = (state_q == REPORT);
    assign timeout       = timeout_q;
    assign early_end     = early_q;
    assign first_err_idx = ferr_idx_q;
    assign first_err_vld = ferr_vld_q;

endmodule

// File: tb/tb_mips_result_checker.sv
// tb/tb_mips_result_checker.sv - randomized self-checking bench for mips_result_checker
module tb_mips_result_checker;
    import mips_tb_pkg::*;

    localparam int          N    = 161;
    localparam logic [29:0] PORT = DEF_TEST_PORT;
    localparam logic [31:0] BSYM = DEF_BEGIN_SYM;
    localparam logic [31:0] ESYM = DEF_END_SYM;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        ld_en;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;

    logic [7:0]  err_a, err_b;
    logic [15:0] dur_a, dur_b;
    logic        fin_a, fin_b, to_a, to_b, early_a, early_b, fvld_a, fvld_b;
    logic [11:0] fidx_a, fidx_b;

    mips_result_checker dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
        .error_num(err_a), .duration(dur_a), .finish(fin_a), .timeout(to_a),
        .early_end(early_a), .first_err_idx(fidx_a), .first_err_vld(fvld_a)
    );

    mips_result_checker #(.TIMEOUT(16'd100)) dut_to (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
        .error_num(err_b), .duration(dur_b), .finish(fin_b), .timeout(to_b),
        .early_end(early_b), .first_err_idx(fidx_b), .first_err_vld(fvld_b)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] tab [N];
    bit          bad [N];
    logic [31:0] wr_q [$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        wen   = 1'b0;
        ld_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_table(input bit rnd);
        for (int i = 0; i < N; i++) begin
            logic [31:0] v;
            if (i == N - 1)  v = ESYM;
            else if (rnd)    v = $urandom;
            else             v = i;
            if (i != N - 1 && v == ESYM) v = v ^ 32'h1;
            ld_en = 1'b1; ld_idx = 12'(i); ld_data = v; tab[i] = v;
            @(negedge clk);
        end
        // Out-of-range indices, including ones that alias low entries if truncated.
        for (int i = 0; i < 4; i++) begin
            ld_en = 1'b1; ld_idx = 12'(256 + i * 3); ld_data = $urandom;
            @(negedge clk);
        end
        ld_en = 1'b0;
    endtask

    task automatic bus_write(input logic [29:0] a, input logic [31:0] d, input int hold, input int gap);
        wen = 1'b1; addr = a; data = d;
        repeat (hold) @(negedge clk);
        wen = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_result(input logic [31:0] d, input int hold, input bit noisy);
        wr_q.push_back(d);
        if (noisy && $urandom_range(0, 3) == 0) begin
            ld_en = 1'b1; ld_idx = 12'($urandom_range(0, N - 1)); ld_data = $urandom;
        end
        wen = 1'b1; addr = PORT; data = d;
        @(negedge clk);
        ld_en = 1'b0;
        repeat (hold - 1) @(negedge clk);
        wen = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        if (noisy && $urandom_range(0, 2) == 0) bus_write(PORT ^ 30'h1, $urandom, 1, 1);
    endtask

    task automatic check_model(input string tag);
        int e = 0, idx = 0, fidx = 0, k = 0;
        bit fv = 0, early = 0, done = 0;
        foreach (wr_q[j]) begin
            if (!done) begin
                if (wr_q[j] != tab[idx]) begin
                    e++;
                    if (!fv) begin fidx = idx; fv = 1; end
                end
                if (wr_q[j] == ESYM && idx < N - 1) begin
                    e += N - 1 - idx; early = 1; done = 1;
                end
                idx++;
                if (idx == N) done = 1;
            end
        end
        if (e > 255) e = 255;
        while (!fin_a && k < 2000) begin @(negedge clk); k++; end
        chk_eq({tag, "_finish"}, 32'(fin_a), 32'(done));
        chk_eq({tag, "_err"}, 32'(err_a), 32'(e));
        chk_eq({tag, "_early"}, 32'(early_a), 32'(early));
        chk_eq({tag, "_timeout"}, 32'(to_a), 32'd0);
        chk_eq({tag, "_fvld"}, 32'(fvld_a), 32'(fv));
        if (fv) chk_eq({tag, "_fidx"}, 32'(fidx_a), 32'(fidx));
    endtask

    task automatic run_seq(input string tag, input int hmin, input int hmax, input int end_at,
                           input bit noisy, input bit load_at_begin);
        wr_q.delete();
        wen = 1'b1; addr = PORT; data = BSYM;
        if (load_at_begin) begin
            logic [31:0] v0;
            v0 = $urandom;
            if (v0 == ESYM) v0 = v0 ^ 32'h1;
            ld_en = 1'b1; ld_idx = 12'd0; ld_data = v0; tab[0] = v0;
        end
        @(negedge clk);
        ld_en = 1'b0;
        wen = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            int h;
            h = $urandom_range(hmin, hmax);
            if (i == end_at) begin
                send_result(ESYM, h, noisy);
                break;
            end
            send_result(bad[i] ? (tab[i] ^ 32'h8000_0001) : tab[i], h, noisy);
        end
        check_model(tag);
    endtask

    initial begin
        int k;
        addr = '0; data = '0; ld_idx = '0; ld_data = '0;
        do_reset();
        chk_eq("rst_err", 32'(err_a), 32'hFF);
        chk_eq("rst_dur", 32'(dur_a), 32'd0);
        chk_eq("rst_finish", 32'(fin_a), 32'd0);
        chk_eq("rst_timeout", 32'(to_a), 32'd0);
        chk_eq("rst_early", 32'(early_a), 32'd0);
        chk_eq("rst_fidx", 32'(fidx_a), 32'd0);
        chk_eq("rst_fvld", 32'(fvld_a), 32'd0);

        load_table(1'b0);
        foreach (bad[i]) bad[i] = 0;
        run_seq("s1", 1, 1, -1, 0, 0);

        do_reset();
        bad[5] = 1; bad[9] = 1;
        run_seq("s2", 1, 1, -1, 0, 0);
        chk_eq("s2_err_const", 32'(err_a), 32'd2);
        chk_eq("s2_fidx_const", 32'(fidx_a), 32'd5);
        foreach (bad[i]) bad[i] = 0;

        do_reset();
        run_seq("s3_stall", 4, 4, -1, 0, 0);
        chk_eq("s3_err_const", 32'(err_a), 32'd0);

        do_reset();
        bus_write(PORT, BSYM, 1, 1);
        for (int i = 0; i < 10; i++) bus_write(PORT, tab[i], 1, 1);
        k = 0;
        while (!fin_b && k < 300) begin @(negedge clk); k++; end
        chk_eq("s4_finish", 32'(fin_b), 32'd1);
        chk_eq("s4_timeout", 32'(to_b), 32'd1);
        chk_eq("s4_dur", 32'(dur_b), 32'd100);
        chk_eq("s4_err", 32'(err_b), 32'd0);
        chk_eq("s4_main_running", 32'(fin_a), 32'd0);

        do_reset();
        run_seq("s5_early", 1, 2, 20, 0, 0);
        chk_eq("s5_err_const", 32'(err_a), 32'd141);

        do_reset();
        bus_write(PORT, BSYM, 1, 1);
        for (int i = 0; i < 50; i++) bus_write(PORT, tab[i] ^ 32'h1, 1, 1);
        rst = 1'b0;
        #1;
        chk_eq("s6_rst_err", 32'(err_a), 32'hFF);
        chk_eq("s6_rst_finish", 32'(fin_a), 32'd0);
        chk_eq("s6_rst_dur", 32'(dur_a), 32'd0);
        chk_eq("s6_rst_fvld", 32'(fvld_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_write(PORT, tab[0], 1, 3);
        chk_eq("s6_idle_dur", 32'(dur_a), 32'd0);
        run_seq("s6_rerun", 1, 1, -1, 0, 0);

        for (int it = 0; it < 5; it++) begin
            do_reset();
            load_table(1'b1);
            foreach (bad[i]) bad[i] = ($urandom_range(0, 15) == 0);
            run_seq($sformatf("rnd%0d", it), 1, 4,
                    (it % 2 == 1) ? int'($urandom_range(0, N - 1)) : -1, 1, (it >= 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
